// File: rtl/dsp_config_chain_loader.sv
// Serialises parallel configuration words onto the DSP tile configuration chain.
// Define DSP_CONFIG_CHAIN_VERIFY_EN to add a CRC-checked rotate-and-verify pass.
module dsp_config_chain_loader #(
   parameter int unsigned CHAIN_LENGTH = 64,
   parameter int unsigned WORD_WIDTH   = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                abort,
   input  logic [WORD_WIDTH-1:0]               cfg_word,
   input  logic                                cfg_word_valid,
   output logic                                cfg_word_ready,
   output logic                                configuration_output,
   output logic                                configuration_enable,
   input  logic                                chain_return,
   output logic                                busy,
   output logic                                done,
   output logic [$clog2(CHAIN_LENGTH+1)-1:0]   bit_count,
   output logic                                verify_ok,
   output logic                                verify_fail
);

   localparam int unsigned BCW  = $clog2(CHAIN_LENGTH + 1);
   localparam int unsigned REMW = $clog2(WORD_WIDTH + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
   localparam logic [1:0] S_VERIFY = 2'd2;
   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
`endif

   logic [1:0]            state, state_nxt;
   logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
   logic [REMW-1:0]       rem, rem_nxt;
   logic [BCW-1:0]        bit_count_nxt;
   logic                  out_q, out_nxt;
   logic                  en_nxt, busy_nxt, done_nxt;
   logic [31:0]           left, nbits;

`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
   logic [15:0] crc_tx, crc_tx_nxt, crc_rx, crc_rx_nxt;
   logic        ok_q, ok_nxt, fail_q, fail_nxt;

   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction
`endif

   // A new word is taken once the previous one is down to its last bit on the wire.
   assign cfg_word_ready = (state == S_LOAD) && (rem == '0) && (bit_count < BCW'(CHAIN_LENGTH));

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      shreg_nxt     = shreg;
      rem_nxt       = rem;
      out_nxt       = 1'b0;
      en_nxt        = 1'b0;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      bit_count_nxt = bit_count;
      left          = CHAIN_LENGTH - 32'(bit_count);
      nbits         = (left < WORD_WIDTH) ? left : WORD_WIDTH;
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
      crc_tx_nxt    = crc_tx;
      crc_rx_nxt    = crc_rx;
      ok_nxt        = 1'b0;
      fail_nxt      = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt     = S_LOAD;
               busy_nxt      = 1'b1;
               bit_count_nxt = '0;
               rem_nxt       = '0;
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
               crc_tx_nxt    = CRC_INIT;
`endif
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
               rem_nxt   = '0;
            end else if (configuration_enable && (bit_count == BCW'(CHAIN_LENGTH))) begin
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
               state_nxt     = S_VERIFY;
               en_nxt        = 1'b1;
               bit_count_nxt = '0;
               crc_rx_nxt    = CRC_INIT;
`else
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
`endif
            end else if (rem != '0) begin
               out_nxt       = shreg[WORD_WIDTH-1];
               shreg_nxt     = shreg << 1;
               rem_nxt       = rem - REMW'(1);
               en_nxt        = 1'b1;
               bit_count_nxt = bit_count + BCW'(1);
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
               crc_tx_nxt    = crc_step(crc_tx, shreg[WORD_WIDTH-1]);
`endif
            end else if (cfg_word_valid && cfg_word_ready) begin
               // Final word may be truncated to the bits still needed.
               out_nxt       = cfg_word[WORD_WIDTH-1];
               shreg_nxt     = cfg_word << 1;
               rem_nxt       = REMW'(nbits - 32'd1);
               en_nxt        = 1'b1;
               bit_count_nxt = bit_count + BCW'(1);
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
               crc_tx_nxt    = crc_step(crc_tx, cfg_word[WORD_WIDTH-1]);
`endif
            end
         end
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
         S_VERIFY: begin
            if (abort) begin
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
            end else begin
               crc_rx_nxt    = crc_step(crc_rx, chain_return);
               bit_count_nxt = bit_count + BCW'(1);
               if (bit_count == BCW'(CHAIN_LENGTH - 1)) begin
                  state_nxt = S_IDLE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  ok_nxt    = (crc_rx_nxt == crc_tx);
                  fail_nxt  = (crc_rx_nxt != crc_tx);
               end else begin
                  en_nxt = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= S_IDLE;
         shreg                <= '0;
         rem                  <= '0;
         out_q                <= 1'b0;
         configuration_enable <= 1'b0;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         bit_count            <= '0;
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
         crc_tx               <= '0;
         crc_rx               <= '0;
         ok_q                 <= 1'b0;
         fail_q               <= 1'b0;
`endif
      end else begin
         state                <= state_nxt;
         shreg                <= shreg_nxt;
         rem                  <= rem_nxt;
         out_q                <= out_nxt;
         configuration_enable <= en_nxt;
         busy                 <= busy_nxt;
         done                 <= done_nxt;
         bit_count            <= bit_count_nxt;
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
         crc_tx               <= crc_tx_nxt;
         crc_rx               <= crc_rx_nxt;
         ok_q                 <= ok_nxt;
         fail_q               <= fail_nxt;
`endif
      end
   end

`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
   // Tail loops straight back to the head so the rotation is exactly CHAIN_LENGTH long.
   assign configuration_output = (state == S_VERIFY) ? chain_return : out_q;
   assign verify_ok            = ok_q;
   assign verify_fail          = fail_q;
`else
   logic unused_chain_return;
   assign unused_chain_return  = chain_return;
   assign configuration_output = out_q;
   assign verify_ok            = 1'b0;
   assign verify_fail          = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_config_chain_loader.sv
// Self-checking bench for dsp_config_chain_loader with a 20-bit chain model.
module tb_dsp_config_chain_loader;

   localparam int CL  = 20;
   localparam int WW  = 8;
   localparam int BCW = $clog2(CL + 1);
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
   localparam int EXP_EN = 2 * CL;
`else
   localparam int EXP_EN = CL;
`endif

   logic           clk = 1'b0;
   logic           reset, start, abort, cfg_word_valid;
   logic [WW-1:0]  cfg_word;
   logic           cfg_word_ready, configuration_output, configuration_enable;
   logic           chain_return, busy, done, verify_ok, verify_fail;
   logic [BCW-1:0] bit_count;

   logic [CL-1:0]  chain     = '0;
   logic [CL-1:0]  flip_mask = '0;

   int   n_chk = 0, n_fail = 0, cyc = 0;
   bit   obs_q[$];
   int   first_en = -1, last_en = -1, done_cnt = 0, done_cyc = -1;
   logic done_ok = 1'b0, done_fail = 1'b0;

   typedef struct {
      logic [WW-1:0] w0, w1, w2;
      int            gap1;
      logic [CL-1:0] exp_chain;
   } vec_t;

   dsp_config_chain_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_word(cfg_word), .cfg_word_valid(cfg_word_valid), .cfg_word_ready(cfg_word_ready),
      .configuration_output(configuration_output), .configuration_enable(configuration_enable),
      .chain_return(chain_return), .busy(busy), .done(done), .bit_count(bit_count),
      .verify_ok(verify_ok), .verify_fail(verify_fail)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Chain model: head at bit 0, tail at bit CL-1
   assign chain_return = chain[CL-1];
   always @(posedge clk) begin
      if (configuration_enable) chain <= {chain[CL-2:0], configuration_output} ^ flip_mask;
      else                      chain <= chain ^ flip_mask;
   end

   always @(negedge clk) begin
      if (configuration_enable) begin
         obs_q.push_back(configuration_output);
         if (first_en < 0) first_en = cyc;
         last_en = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_ok   = verify_ok;
         done_fail = verify_fail;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clr_mon();
      obs_q.delete();
      first_en = -1; last_en = -1; done_cnt = 0; done_cyc = -1;
      done_ok = 1'b0; done_fail = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         ok = cfg_word_ready;
      end
      if (!ok) chk({tag, "_ready_timeout"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_bc(input int v);
      bit ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         ok = (32'(bit_count) == 32'(v));
      end
      if (!ok) chk("bit_count_timeout", 32'(bit_count), 32'(v));
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) chk({tag, "_done_timeout"}, 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic send_word(input logic [WW-1:0] w, input int gap);
      if (gap > 0) begin
         cfg_word_valid = 1'b0;
         wait_ready("gap");
         repeat (gap) @(posedge clk);
         #1;
      end
      cfg_word       = w;
      cfg_word_valid = 1'b1;
      wait_ready("word");
      @(posedge clk);
      #1;
      cfg_word_valid = 1'b0;
   endtask

   task automatic start_load();
      clr_mon();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_load(input logic [WW-1:0] ws [3], input int g1, input int g2, input string tag);
      start_load();
      send_word(ws[0], 0);
      send_word(ws[1], g1);
      send_word(ws[2], g2);
      @(negedge clk);
      chk({tag, "_ready_after_last"}, 32'(cfg_word_ready), 32'd0);
      wait_done(tag);
   endtask

   // Reference: the chain holds the first CL bits of the MSB-first word stream.
   function automatic logic [CL-1:0] model_chain(input logic [WW-1:0] ws [3]);
      logic [CL-1:0] c = '0;
      int n = 0;
      for (int w = 0; w < 3; w++)
         for (int b = WW - 1; b >= 0; b--)
            if (n < CL) begin
               c = {c[CL-2:0], ws[w][b]};
               n++;
            end
      return c;
   endfunction

   task automatic check_load(input logic [WW-1:0] ws [3], input logic [CL-1:0] exp_chain,
                             input int gaps, input string tag);
      bit exp_q[$];
      int mism = 0;
      for (int w = 0; w < 3; w++)
         for (int b = WW - 1; b >= 0; b--)
            if (exp_q.size() < CL) exp_q.push_back(ws[w][b]);
      for (int i = 0; i < CL && i < obs_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      chk({tag, "_enable_cycles"}, 32'(obs_q.size()), 32'(EXP_EN));
      chk({tag, "_stream_bits"},   32'(mism), 32'd0);
      chk({tag, "_enable_span"},   32'(last_en - first_en + 1), 32'(EXP_EN + gaps));
      chk({tag, "_done_latency"},  32'(done_cyc), 32'(last_en + 1));
      chk({tag, "_done_count"},    32'(done_cnt), 32'd1);
      chk({tag, "_chain"},         32'(chain), 32'(exp_chain));
      chk({tag, "_bit_count"},     32'(bit_count), 32'(CL));
      chk({tag, "_idle_outputs"},  32'({busy, configuration_enable}), 32'd0);
`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
      chk({tag, "_verify_flags"},  32'({done_ok, done_fail}), 32'b10);
`else
      chk({tag, "_verify_flags"},  32'({done_ok, done_fail}), 32'b00);
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t          vt [4];
      logic [WW-1:0] ws [3];
      int            g1, g2;
      bit            hit;

      vt[0] = '{w0: 8'hA5, w1: 8'h3C, w2: 8'hF0, gap1: 0, exp_chain: 20'hA53CF};
      vt[1] = '{w0: 8'hA5, w1: 8'h3C, w2: 8'hF0, gap1: 5, exp_chain: 20'hA53CF};
      vt[2] = '{w0: 8'hFF, w1: 8'h00, w2: 8'h5A, gap1: 0, exp_chain: 20'hFF005};
      vt[3] = '{w0: 8'h12, w1: 8'h34, w2: 8'h56, gap1: 2, exp_chain: 20'h12345};

      reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_word_valid = 1'b0; cfg_word = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'({configuration_enable, configuration_output, cfg_word_ready,
                                busy, done, verify_ok, verify_fail}), 32'd0);
      chk("reset_bit_count", 32'(bit_count), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Valid while idle is ignored
      cfg_word = 8'hFF;
      cfg_word_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_valid_ignored", 32'({cfg_word_ready, configuration_enable, busy}), 32'd0);
      end
      @(posedge clk);
      #1;
      cfg_word_valid = 1'b0;

      for (int i = 0; i < 4; i++) begin
         ws = '{vt[i].w0, vt[i].w1, vt[i].w2};
         run_load(ws, vt[i].gap1, 0, $sformatf("vec%0d", i));
         check_load(ws, vt[i].exp_chain, vt[i].gap1, $sformatf("vec%0d", i));
      end

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 3; k++) ws[k] = WW'($urandom);
         g1 = int'($urandom_range(0, 4));
         g2 = int'($urandom_range(0, 4));
         run_load(ws, g1, g2, $sformatf("rand%0d", r));
         check_load(ws, model_chain(ws), g1 + g2, $sformatf("rand%0d", r));
      end

      // Stall: enable and bit_count freeze while no word is offered
      ws = '{8'hA5, 8'h3C, 8'hF0};
      start_load();
      send_word(ws[0], 0);
      wait_ready("stall");
      repeat (3) begin
         @(negedge clk);
         chk("stall_enable_out", 32'({configuration_enable, configuration_output}), 32'd0);
         chk("stall_bit_count", 32'(bit_count), 32'd8);
      end
      @(posedge clk);
      #1;
      send_word(ws[1], 0);
      send_word(ws[2], 0);
      wait_done("stall");
      check_load(ws, 20'hA53CF, 4, "stall");

      // Start and abort together in IDLE: start wins; then abort at bit_count 10
      clr_mon();
      start = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_beats_abort", 32'(busy), 32'd1);
      send_word(8'hA5, 0);
      cfg_word = 8'h3C;
      cfg_word_valid = 1'b1;
      wait_bc(10);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0; cfg_word_valid = 1'b0;
      @(negedge clk);
      chk("abort_outputs", 32'({busy, configuration_enable, done}), 32'd0);
      repeat (4) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      @(posedge clk);
      #1;
      run_load(ws, 0, 0, "after_abort");
      check_load(ws, 20'hA53CF, 0, "after_abort");

      // Reset mid-load
      start_load();
      send_word(8'hA5, 0);
      wait_bc(4);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midreset_outputs", 32'({configuration_enable, configuration_output, cfg_word_ready,
                                   busy, done, verify_ok, verify_fail}), 32'd0);
      chk("midreset_bit_count", 32'(bit_count), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Start while busy is ignored
      start_load();
      send_word(ws[0], 0);
      wait_bc(5);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_busy_bit_count", 32'(bit_count), 32'd6);
      chk("start_busy_busy", 32'(busy), 32'd1);
      send_word(ws[1], 0);
      send_word(ws[2], 0);
      wait_done("start_busy");
      check_load(ws, 20'hA53CF, 0, "start_busy");

`ifdef DSP_CONFIG_CHAIN_VERIFY_EN
      // Corrupt the chain at the LOAD/VERIFY boundary
      start_load();
      send_word(ws[0], 0);
      send_word(ws[1], 0);
      send_word(ws[2], 0);
      hit = 1'b0;
      for (int i = 0; i < 64 && !hit; i++) begin
         @(negedge clk);
         hit = busy && configuration_enable && (32'(bit_count) == 32'(CL));
      end
      if (!hit) chk("fault_load_end_timeout", 32'(hit), 32'd1);
      flip_mask[CL-1] = 1'b1;
      @(posedge clk);
      #1;
      flip_mask = '0;
      wait_done("fault");
      chk("fault_verify_flags", 32'({done_ok, done_fail}), 32'b01);
      chk("fault_done_count", 32'(done_cnt), 32'd1);
`else
      hit = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_config_chain_loader.md
Name: dsp_config_chain_loader

Overview:
- Drives the serial configuration chain that threads through every sub-block of the DSP tile.
- Takes parallel configuration words over a valid/ready stream and serialises them onto the chain's head input.
- Generates the chain's shift-enable and counts exactly CHAIN_LENGTH shifts.
- Optionally rotates the chain once more to verify the loaded contents by CRC, using the bit returned from the chain tail.

Parameters:
- CHAIN_LENGTH, 64, total configuration bits in the chain (≥2).
- WORD_WIDTH, 8, width of each input configuration word (≥1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE.
- abort  input  1  cancel an in-progress load or verify.
- cfg_word  input  WORD_WIDTH  configuration word.
- cfg_word_valid  input  1  cfg_word is valid.
- cfg_word_ready  output  1  loader accepts cfg_word this cycle.
- configuration_output  output  1  serial bit to the chain head (the first block's configuration_input).
- configuration_enable  output  1  chain shift enable.
- chain_return  input  1  configuration_output of the last block in the chain.
- busy  output  1  high in LOAD or VERIFY.
- done  output  1  one-cycle completion pulse.
- bit_count  output  clog2(CHAIN_LENGTH+1)  bits shifted in the current pass.
- verify_ok  output  1  pulse with done when CRCs match (feature only; tied 0 otherwise).
- verify_fail  output  1  pulse with done when CRCs differ (feature only; tied 0 otherwise).

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register empty; bit_count 0.
- Reset mid-operation abandons the pass immediately. configuration_enable is 0 the following cycle.
- States and transitions:
  - IDLE -> LOAD on start. In IDLE, configuration_enable=0 and cfg_word_ready=0.
  - LOAD: a word is accepted when cfg_word_valid & cfg_word_ready.
  - cfg_word_ready=1 when the shift register is empty, or when it holds its last pending bit and bit_count+1 < CHAIN_LENGTH. This gives zero-gap back-to-back words.
  - cfg_word_ready=0 once all bits needed to reach CHAIN_LENGTH have been accepted.
  - Bits are sent MSB first. The word accepted in cycle k puts its MSB on configuration_output with configuration_enable=1 in cycle k+1. It then shifts one bit per cycle for WORD_WIDTH cycles.
  - configuration_output and configuration_enable are registered in LOAD.
  - Final word when CHAIN_LENGTH mod WORD_WIDTH = r ≠ 0: only its r upper bits are sent; the remainder is discarded.
  - Underflow (no pending bit, valid low): configuration_enable=0, configuration_output=0, bit_count holds. The chain contents are unchanged.
  - bit_count increments on every enable cycle. On the cycle bit_count reaches CHAIN_LENGTH, LOAD ends.
  - Without the feature: next cycle done=1, busy=0, state IDLE. bit_count holds its final value until the next start, which clears it.
  - ABORT: abort in LOAD/VERIFY -> next cycle IDLE, configuration_enable=0, busy=0, no done. Chain contents are left partially shifted.
- Simultaneous events:
  - start while busy: ignored.
  - start & abort in IDLE: start wins.
  - abort & final bit in the same cycle: abort wins, no done.
  - cfg_word_valid outside LOAD: ignored; ready stays 0.

Optional Feature:
- Macro: DSP_CONFIG_CHAIN_VERIFY_EN.
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, one serial bit per enable cycle.
- LOAD: crc_tx is updated with every bit sent.
- LOAD -> VERIFY after the final load bit, bit_count cleared.
- VERIFY: configuration_enable=1 for exactly CHAIN_LENGTH consecutive cycles.
- VERIFY: configuration_output = chain_return, combinational, so the chain rotates and is restored. It must not be registered, or the loop length becomes CHAIN_LENGTH+1.
- VERIFY: crc_rx is updated with chain_return on each enable cycle.
- End of VERIFY: the cycle after the last enable, done=1 with exactly one of verify_ok/verify_fail=1, then IDLE.
- Without the macro: no VERIFY state, no CRC logic, verify_ok=verify_fail=0.

Test Plan:
- Load, 3 words: CHAIN_LENGTH=20, WORD_WIDTH=8, chain modelled as a 20-bit shift register. Words 0xA5, 0x3C, 0xF0 presented back-to-back -> 20 consecutive enable cycles, no gaps. Serial stream is 1010_0101_0011_1100_1111. done one cycle after the 20th enable; low nibble of 0xF0 never shifted; cfg_word_ready=0 after the third accept.
- Stall: valid dropped for 5 cycles after word 1 -> configuration_enable=0 for those 5 cycles, bit_count holds at 8. Final chain contents identical to the first test.
- Abort: abort asserted when bit_count=10 -> next cycle busy=0, configuration_enable=0, no done pulse. A following start reloads cleanly to bit_count=20.
- Reset / ignored start: reset asserted mid-load -> all outputs 0 next cycle. start pulsed while busy -> no restart, bit_count continues.
- Verify (macro on, clean): clean load -> 20 verify enable cycles, chain contents restored, verify_ok=1 with done.
- Verify (macro on, fault): one chain-model bit flipped between LOAD and VERIFY -> verify_fail=1 with done.
